l15_responder: RTL and testbench

Synthesizable responder for the L1.5 request/return interface that the core tile's L1.5 adapter drives toward OpenPiton. It accepts one request at a time on the packed L1.5 request bus and answers on the packed return bus from a 64-bit-word backing store after a fixed latency. It can also inject invalidations toward the tile. It stands in for the OpenPiton L1.5 in tile-level benches and FPGA bring-up without a NoC.

---
 rtl/wt_cache_pkg.sv | 90 +++++++++
 rtl/l15_resp_mem.sv | 50 +++++
 rtl/l15_responder.sv | 166 ++++++++++++++++
 tb/tb_l15_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// L1.5 request/return bus types shared by the core-tile adapter and the responder,
// plus the store byte-mask helper used by both sides.
package wt_cache_pkg;

  localparam int L15_TID_WIDTH     = 2;
  localparam int L15_WAY_WIDTH     = 2;
  localparam int L15_TLB_CSM_WIDTH = 33;

  typedef enum logic [4:0] {
    L15_LOAD_RQ   = 5'b00000,
    L15_STORE_RQ  = 5'b00001,
    L15_CAS1_RQ   = 5'b00010,
    L15_CAS2_RQ   = 5'b00011,
    L15_ATOMIC_RQ = 5'b00110,
    L15_IMISS_RQ  = 5'b10000
  } l15_reqtypes_t;

  typedef enum logic [3:0] {
    L15_LOAD_RET               = 4'b0000,
    L15_IFILL_RET              = 4'b0001,
    L15_STRLOAD_RET            = 4'b0010,
    L15_EVICT_REQ              = 4'b0011,
    L15_ST_ACK                 = 4'b0100,
    L15_TEST_RET               = 4'b0101,
    L15_STRST_ACK              = 4'b0110,
    L15_INT_RET                = 4'b0111,
    L15_FP_RET                 = 4'b1000,
    L15_ERR_RET                = 4'b1100,
    L15_CPX_RESTYPE_ATOMIC_RES = 4'b1110
  } l15_rtrntypes_t;

  typedef struct packed {
    logic                         l15_val;
    logic                         l15_req_ack;
    l15_reqtypes_t                l15_rqtype;
    logic                         l15_nc;
    logic [2:0]                   l15_size;
    logic [L15_TID_WIDTH-1:0]     l15_threadid;
    logic                         l15_prefetch;
    logic                         l15_invalidate_cacheline;
    logic                         l15_blockstore;
    logic                         l15_blockinitstore;
    logic [L15_WAY_WIDTH-1:0]     l15_l1rplway;
    logic [39:0]                  l15_address;
    logic [63:0]                  l15_data;
    logic [63:0]                  l15_data_next_entry;
    logic [L15_TLB_CSM_WIDTH-1:0] l15_csm_data;
    logic [3:0]                   l15_amo_op;
  } l15_req_t;

  typedef struct packed {
    logic                     l15_ack;
    logic                     l15_header_ack;
    logic                     l15_val;
    l15_rtrntypes_t           l15_returntype;
    logic                     l15_l2miss;
    logic [1:0]               l15_error;
    logic                     l15_noncacheable;
    logic                     l15_atomic;
    logic [L15_TID_WIDTH-1:0] l15_threadid;
    logic                     l15_prefetch;
    logic                     l15_f4b;
    logic [63:0]              l15_data_0;
    logic [63:0]              l15_data_1;
    logic [63:0]              l15_data_2;
    logic [63:0]              l15_data_3;
    logic                     l15_inval_icache_all_way;
    logic                     l15_inval_dcache_all_way;
    logic [15:4]              l15_inval_address_15_4;
    logic                     l15_cross_invalidate;
    logic [1:0]               l15_cross_invalidate_way;
    logic                     l15_inval_dcache_inval;
    logic                     l15_inval_icache_inval;
    logic [L15_WAY_WIDTH-1:0] l15_inval_way;
    logic                     l15_blockinitstore;
  } l15_rtrn_t;

  // Size codes beyond 8 B are treated as a full word; misaligned masks are truncated.
  function automatic logic [7:0] l15_bytemask(input logic [2:0] size, input logic [2:0] addr);
    logic [7:0] base;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << addr;
  endfunction

endpackage

// File: rtl/l15_resp_mem.sv
// Backing store split into four 64-bit banks so a whole 32 B block reads in one cycle.
// Store byte-writes and full-word backdoor writes share the banks; the store wins on a clash.
module l15_resp_mem #(
  parameter int MemWords = 1024
) (
  input  logic                        clk_i,
  input  logic                        st_we,
  input  logic [$clog2(MemWords)-1:0] st_addr,
  input  logic [7:0]                  st_be,
  input  logic [63:0]                 st_wdata,
  input  logic                        bd_we,
  input  logic [$clog2(MemWords)-1:0] bd_addr,
  input  logic [63:0]                 bd_wdata,
  input  logic                        rd_en,
  input  logic [((($clog2(MemWords)) > 2) ? ($clog2(MemWords) - 2) : 1)-1:0] rd_row,
  output logic [3:0][63:0]            rd_data
);
  localparam int IdxW = $clog2(MemWords);
  localparam int RowW = (IdxW > 2) ? IdxW - 2 : 1;
  localparam int Rows = MemWords / 4;

  logic [RowW-1:0] st_row;
  logic [RowW-1:0] bd_row;

  assign st_row = RowW'(st_addr >> 2);
  assign bd_row = RowW'(bd_addr >> 2);

  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    logic [63:0] mem [Rows];
    logic [63:0] rd_reg;

    // Store bytes are assigned after the backdoor word so they take priority.
    always_ff @(posedge clk_i) begin
      if (bd_we && bd_addr[1:0] == 2'(gi)) begin
        mem[bd_row] <= bd_wdata;
      end
      for (int b = 0; b < 8; b++) begin
        if (st_we && st_addr[1:0] == 2'(gi) && st_be[b]) begin
          mem[st_row][8*b +: 8] <= st_wdata[8*b +: 8];
        end
      end
      if (rd_en) begin
        rd_reg <= mem[rd_row];
      end
    end

    assign rd_data[gi] = rd_reg;
  end

endmodule

// File: rtl/l15_responder.sv
// Stand-in for the OpenPiton L1.5: accepts one request at a time, answers after a fixed
// latency from a local word store, and injects invalidations on request.
module l15_responder
  import wt_cache_pkg::*;
#(
  parameter int MemWords = 1024,
  parameter int Latency  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [$bits(l15_req_t)-1:0]  l15_req_i,
  output logic [$bits(l15_rtrn_t)-1:0] l15_rtrn_o,
  input  logic                         inval_req_i,
  input  logic [39:0]                  inval_addr_i,
  input  logic                         bd_we_i,
  input  logic [$clog2(MemWords)-1:0]  bd_addr_i,
  input  logic [63:0]                  bd_wdata_i,
  output logic                         err_o
);
  localparam int IdxW = $clog2(MemWords);
  localparam int RowW = (IdxW > 2) ? IdxW - 2 : 1;
  localparam int CntW = (Latency > 2) ? $clog2(Latency) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, INVAL} state_e;

  l15_req_t                 req;
  l15_rtrn_t                rtrn;
  state_e                   state_reg;
  logic [CntW-1:0]          cnt_reg;
  logic [4:0]               rqtype_reg;
  logic                     nc_reg;
  logic [L15_TID_WIDTH-1:0] tid_reg;
  logic [IdxW-1:0]          word_reg;
  logic                     inval_pend_reg;
  logic [11:0]              inval_addr_reg;
  logic                     err_reg;

  logic            accept;
  logic            st_we;
  logic [IdxW-1:0] req_word;
  logic [IdxW-1:0] rd_word;
  logic            rd_en;
  logic [RowW-1:0] rd_row;
  logic [3:0][63:0] rd_data;
  logic            unused_in;

  assign req       = l15_req_t'(l15_req_i);
  assign unused_in = ^{l15_req_i, inval_addr_i[39:16], inval_addr_i[3:0]};

  assign accept   = (state_reg == IDLE) && req.l15_val;
  assign st_we    = accept && (req.l15_rqtype == L15_STORE_RQ);
  assign req_word = req.l15_address[3 +: IdxW];

  // Read one cycle before RESP; with a single-cycle latency that is the accept cycle itself.
  assign rd_en   = ((state_reg == WAIT) && (cnt_reg == '0)) || (accept && (Latency == 1));
  assign rd_word = (state_reg == IDLE) ? req_word : word_reg;
  assign rd_row  = RowW'(rd_word >> 2);

  l15_resp_mem #(.MemWords(MemWords)) u_mem (
    .clk_i   (clk_i),
    .st_we   (st_we),
    .st_addr (req_word),
    .st_be   (l15_bytemask(req.l15_size, req.l15_address[2:0])),
    .st_wdata(req.l15_data),
    .bd_we   (bd_we_i),
    .bd_addr (bd_addr_i),
    .bd_wdata(bd_wdata_i),
    .rd_en   (rd_en),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      rqtype_reg     <= '0;
      nc_reg         <= 1'b0;
      tid_reg        <= '0;
      word_reg       <= '0;
      inval_pend_reg <= 1'b0;
      inval_addr_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req.l15_val) begin
            rqtype_reg <= req.l15_rqtype;
            nc_reg     <= req.l15_nc;
            tid_reg    <= req.l15_threadid;
            word_reg   <= req_word;
            if (!(req.l15_rqtype inside {L15_LOAD_RQ, L15_IMISS_RQ, L15_STORE_RQ})) begin
              err_reg <= 1'b1;
            end
            if (Latency == 1) begin
              state_reg <= RESP;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= CntW'(Latency - 2);
            end
          end else if (inval_pend_reg) begin
            state_reg <= INVAL;
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      // A pulse during INVAL re-arms the pending entry rather than being lost.
      if (inval_req_i) begin
        inval_pend_reg <= 1'b1;
        inval_addr_reg <= inval_addr_i[15:4];
      end else if (state_reg == INVAL) begin
        inval_pend_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    rtrn                = '0;
    rtrn.l15_header_ack = accept;
    rtrn.l15_ack        = accept;
    if (state_reg == RESP) begin
      rtrn.l15_val      = 1'b1;
      rtrn.l15_threadid = tid_reg;
      case (rqtype_reg)
        L15_LOAD_RQ: begin
          rtrn.l15_returntype = L15_LOAD_RET;
          if (nc_reg) begin
            rtrn.l15_data_0 = rd_data[word_reg[1:0]];
            rtrn.l15_data_1 = rd_data[word_reg[1:0]];
          end else begin
            rtrn.l15_data_0 = rd_data[{word_reg[1], 1'b0}];
            rtrn.l15_data_1 = rd_data[{word_reg[1], 1'b1}];
          end
        end
        L15_IMISS_RQ: begin
          rtrn.l15_returntype = L15_IFILL_RET;
          rtrn.l15_data_0     = rd_data[0];
          rtrn.l15_data_1     = rd_data[1];
          rtrn.l15_data_2     = rd_data[2];
          rtrn.l15_data_3     = rd_data[3];
        end
        L15_STORE_RQ: rtrn.l15_returntype = L15_ST_ACK;
        default:      rtrn.l15_returntype = L15_LOAD_RET;
      endcase
    end else if (state_reg == INVAL) begin
      rtrn.l15_val                = 1'b1;
      rtrn.l15_returntype         = L15_EVICT_REQ;
      rtrn.l15_inval_address_15_4 = inval_addr_reg;
      rtrn.l15_inval_dcache_inval = 1'b1;
      rtrn.l15_inval_icache_inval = 1'b1;
    end
  end

  assign l15_rtrn_o = rtrn;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_l15_responder.sv
// Directed bench for l15_responder: table of request/return vectors plus hand-written
// sequences for invalidation arbitration, backdoor/store clash and reset mid-transaction.
module tb_l15_responder;
  import wt_cache_pkg::*;

  localparam int MemWords = 1024;
  localparam int Latency  = 4;
  localparam int RW       = $bits(l15_rtrn_t);

  localparam logic [63:0] W10 = 64'h1111111111111111;
  localparam logic [63:0] W11 = 64'h2222222222222222;
  localparam logic [63:0] W12 = 64'h3333333333333333;
  localparam logic [63:0] W13 = 64'h4444444444444444;
  localparam logic [63:0] W01 = 64'hA5A5A5A55A5A5A5A;

  typedef struct packed {
    l15_reqtypes_t  rqtype;
    logic           nc;
    logic [2:0]     size;
    logic [1:0]     tid;
    logic [39:0]    addr;
    logic [63:0]    data;
    l15_rtrntypes_t rtype;
    logic [63:0]    d0;
    logic [63:0]    d1;
    logic [63:0]    d2;
    logic [63:0]    d3;
    logic           err;
  } vec_t;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  l15_req_t             l15_req = '0;
  l15_rtrn_t            rtrn;
  logic                 inval_req = 1'b0;
  logic [39:0]          inval_addr = '0;
  logic                 bd_we = 1'b0;
  logic [9:0]           bd_addr = '0;
  logic [63:0]          bd_wdata = '0;
  logic                 err_o;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs [12];

  always #5 clk_i = ~clk_i;

  l15_responder #(.MemWords(MemWords), .Latency(Latency)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .l15_req_i   (l15_req),
    .l15_rtrn_o  (rtrn),
    .inval_req_i (inval_req),
    .inval_addr_i(inval_addr),
    .bd_we_i     (bd_we),
    .bd_addr_i   (bd_addr),
    .bd_wdata_i  (bd_wdata),
    .err_o       (err_o)
  );

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic l15_rtrn_t exp_of(input vec_t v);
    l15_rtrn_t e;
    e                = '0;
    e.l15_val        = 1'b1;
    e.l15_returntype = v.rtype;
    e.l15_threadid   = v.tid;
    e.l15_data_0     = v.d0;
    e.l15_data_1     = v.d1;
    e.l15_data_2     = v.d2;
    e.l15_data_3     = v.d3;
    return e;
  endfunction

  task automatic bd_write(input logic [9:0] idx, input logic [63:0] d);
    bd_we    = 1'b1;
    bd_addr  = idx;
    bd_wdata = d;
    @(posedge clk_i);
    #1;
    bd_we = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    l15_req              = '0;
    l15_req.l15_val      = 1'b1;
    l15_req.l15_rqtype   = v.rqtype;
    l15_req.l15_nc       = v.nc;
    l15_req.l15_size     = v.size;
    l15_req.l15_threadid = v.tid;
    l15_req.l15_address  = v.addr;
    l15_req.l15_data     = v.data;
  endtask

  // Holds the request until ack, then drops it (and any side pulses) after the accept edge.
  task automatic accept_wait(input string name);
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (rtrn.l15_ack && rtrn.l15_header_ack) begin
        got = 1;
        break;
      end
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_ack: got no ack in 20 cycles, expected ack", name);
    end
    @(posedge clk_i);
    #1;
    l15_req   = '0;
    inval_req = 1'b0;
    bd_we     = 1'b0;
  endtask

  task automatic ret_check(input string name, input l15_rtrn_t exp, input logic exp_err);
    for (int k = 1; k <= Latency + 1; k++) begin
      @(negedge clk_i);
      if (k == Latency) begin
        chk($sformatf("%s_ret", name), rtrn, exp);
        chk_bit($sformatf("%s_err", name), err_o, exp_err);
      end else begin
        chk($sformatf("%s_quiet%0d", name, k), rtrn, '0);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    drive(v);
    accept_wait(name);
    ret_check(name, exp_of(v), v.err);
  endtask

  initial begin
    vec_t      v;
    l15_rtrn_t e;

    vecs[0]  = '{L15_IMISS_RQ,  1'b0, 3'd0, 2'd1, 40'h80,   64'h0,
                 L15_IFILL_RET, W10, W11, W12, W13, 1'b0};
    vecs[1]  = '{L15_STORE_RQ,  1'b0, 3'd1, 2'd2, 40'h86,   64'hBEEFBEEFBEEFBEEF,
                 L15_ST_ACK, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0};
    vecs[2]  = '{L15_LOAD_RQ,   1'b0, 3'd3, 2'd3, 40'h80,   64'h0,
                 L15_LOAD_RET, 64'hBEEF111111111111, W11, 64'h0, 64'h0, 1'b0};
    vecs[3]  = '{L15_LOAD_RQ,   1'b0, 3'd3, 2'd0, 40'h98,   64'h0,
                 L15_LOAD_RET, W12, W13, 64'h0, 64'h0, 1'b0};
    vecs[4]  = '{L15_LOAD_RQ,   1'b1, 3'd3, 2'd1, 40'h2008, 64'h0,
                 L15_LOAD_RET, W01, W01, 64'h0, 64'h0, 1'b0};
    vecs[5]  = '{L15_STORE_RQ,  1'b0, 3'd0, 2'd2, 40'h91,   64'h5A5A5A5A5A5A5A5A,
                 L15_ST_ACK, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0};
    vecs[6]  = '{L15_LOAD_RQ,   1'b1, 3'd3, 2'd3, 40'h90,   64'h0,
                 L15_LOAD_RET, 64'h3333333333335A33, 64'h3333333333335A33, 64'h0, 64'h0, 1'b0};
    vecs[7]  = '{L15_STORE_RQ,  1'b0, 3'd2, 2'd0, 40'h9C,   64'hCAFEF00DCAFEF00D,
                 L15_ST_ACK, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0};
    vecs[8]  = '{L15_STORE_RQ,  1'b0, 3'd3, 2'd1, 40'h88,   64'h0123456789ABCDEF,
                 L15_ST_ACK, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0};
    vecs[9]  = '{L15_IMISS_RQ,  1'b0, 3'd0, 2'd2, 40'h98,   64'h0,
                 L15_IFILL_RET, 64'hBEEF111111111111, 64'h0123456789ABCDEF,
                 64'h3333333333335A33, 64'hCAFEF00D44444444, 1'b0};
    vecs[10] = '{L15_ATOMIC_RQ, 1'b0, 3'd3, 2'd3, 40'h80,   64'hFFFFFFFFFFFFFFFF,
                 L15_LOAD_RET, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1};
    vecs[11] = '{L15_LOAD_RQ,   1'b0, 3'd3, 2'd0, 40'h88,   64'h0,
                 L15_LOAD_RET, 64'hBEEF111111111111, 64'h0123456789ABCDEF, 64'h0, 64'h0, 1'b1};

    repeat (3) @(negedge clk_i);
    chk("reset_rtrn", rtrn, '0);
    chk_bit("reset_err", err_o, 1'b0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    bd_write(10'h010, W10);
    bd_write(10'h011, W11);
    bd_write(10'h012, W12);
    bd_write(10'h013, W13);
    bd_write(10'h001, W01);

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Request and invalidation in the same cycle: load first, eviction two cycles after its return.
    v = '{L15_LOAD_RQ, 1'b0, 3'd3, 2'd1, 40'h90, 64'h0,
          L15_LOAD_RET, 64'h3333333333335A33, 64'hCAFEF00D44444444, 64'h0, 64'h0, 1'b1};
    drive(v);
    inval_req  = 1'b1;
    inval_addr = 40'h12340;
    accept_wait("inv");
    e                         = '0;
    e.l15_val                 = 1'b1;
    e.l15_returntype          = L15_EVICT_REQ;
    e.l15_inval_address_15_4  = 12'h234;
    e.l15_inval_dcache_inval  = 1'b1;
    e.l15_inval_icache_inval  = 1'b1;
    for (int k = 1; k <= Latency + 3; k++) begin
      @(negedge clk_i);
      if (k == Latency) chk("inv_load_ret", rtrn, exp_of(v));
      else if (k == Latency + 2) chk("inv_evict", rtrn, e);
      else chk($sformatf("inv_quiet%0d", k), rtrn, '0);
    end
    @(posedge clk_i);
    #1;

    // Backdoor and store hit the same word in the accept cycle: store data must survive.
    v = '{L15_STORE_RQ, 1'b0, 3'd3, 2'd2, 40'h100, 64'hDEADBEEFCAFEBABE,
          L15_ST_ACK, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1};
    drive(v);
    bd_we    = 1'b1;
    bd_addr  = 10'h020;
    bd_wdata = 64'hFFFFFFFFFFFFFFFF;
    accept_wait("clash");
    ret_check("clash", exp_of(v), 1'b1);
    v = '{L15_LOAD_RQ, 1'b1, 3'd3, 2'd3, 40'h100, 64'h0,
          L15_LOAD_RET, 64'hDEADBEEFCAFEBABE, 64'hDEADBEEFCAFEBABE, 64'h0, 64'h0, 1'b1};
    run_vec("clash_rd", v);

    // Reset while waiting: transaction dropped, outputs and sticky error cleared.
    v = '{L15_LOAD_RQ, 1'b0, 3'd3, 2'd1, 40'h80, 64'h0,
          L15_LOAD_RET, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0};
    drive(v);
    accept_wait("rst");
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("rst_rtrn", rtrn, '0);
    chk_bit("rst_err", err_o, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 1; k <= Latency + 2; k++) begin
      @(negedge clk_i);
      chk($sformatf("rst_quiet%0d", k), rtrn, '0);
    end
    @(posedge clk_i);
    #1;
    v = '{L15_LOAD_RQ, 1'b1, 3'd3, 2'd2, 40'h88, 64'h0,
          L15_LOAD_RET, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'h0, 64'h0, 1'b0};
    run_vec("post_rst", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
